// File: rtl/bids22defs.sv
// Shared type definitions for the sealed-bid auction block: FSM states,
// top-level and per-bidder error codes, and the control-port opcodes.
package bids22defs;

  typedef enum logic [2:0] {
    RESET,
    UNLOCKED,
    COOLDOWN,
    LOCKED,
    ROUNDSTARTED,
    ROUNDOVER,
    READYNEXT
  } states_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ALREADYUNLOCKED,
    CSTARTWHENUNLOCKED,
    BADKEY,
    INVALID_OP,
    DUPLICATEBIDS
  } outerrors_t;

  typedef enum logic [2:0] {
    BID_OK,
    ROUNDINACTIVE,
    INSUFFICIENTFUNDS,
    INVALIDREQUEST
  } biderrors_t;

  typedef enum logic [3:0] {
    NO_OP,
    UNLOCK,
    LOCK,
    LOADBAL,
    SETMASK,
    SETTIMER,
    SETBIDCHARGE
  } opcodes_t;

endpackage

// File: rtl/bids_maxfind.sv
// Combinational N-way maximum over packed unsigned values. Flags a tie at a
// nonzero maximum and gives a one-hot winner only for a unique nonzero maximum.
module bids_maxfind #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic [N*W-1:0] vals,
  output logic [W-1:0]   max_val,
  output logic           dup,
  output logic [N-1:0]   win_onehot
);

  logic seen;

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves a
    // value held (no latch); blocking assignments because this is pure logic.
    max_val    = '0;
    dup        = 1'b0;
    win_onehot = '0;
    seen       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vals[i*W +: W] > max_val) max_val = vals[i*W +: W];
    end
    for (int i = 0; i < N; i++) begin
      if (max_val != '0 && vals[i*W +: W] == max_val) begin
        if (seen) dup = 1'b1;
        else      win_onehot[i] = 1'b1;
        seen = 1'b1;
      end
    end
    if (dup) win_onehot = '0;
  end

endmodule

// File: rtl/bids_auction_n.sv
// N-bidder sealed-bid auction controller with key lock and bad-key cooldown.
// Optional feature macro BIDS_RETRACT_EN adds in-round bid retraction.
module bids_auction_n
  import bids22defs::*;
#(
  parameter int DATAWIDTH       = 32,
  parameter int NUMBIDDERS      = 3,
  parameter int COOLDOWN_CYCLES = 7
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DATAWIDTH-1:0]             C_data,
  input  logic [3:0]                       C_op,
  input  logic                             C_start,
  input  logic [NUMBIDDERS-1:0]            bid,
  input  logic [NUMBIDDERS*(DATAWIDTH/2)-1:0] bidAmt,
  input  logic [NUMBIDDERS-1:0]            retract,
  output logic [NUMBIDDERS-1:0]            ack,
  output logic [NUMBIDDERS*3-1:0]          bidErr,
  output logic [NUMBIDDERS*DATAWIDTH-1:0]  balance,
  output logic [NUMBIDDERS-1:0]            win,
  output logic                             ready,
  output logic [2:0]                       err,
  output logic                             roundOver,
  output logic [DATAWIDTH-1:0]             maxBid
);

  localparam int BIDAMTBITS = DATAWIDTH / 2;
  localparam int IDXW       = $clog2(NUMBIDDERS);
  localparam int SUMW       = DATAWIDTH + 1;
  localparam int CDW        = $clog2(COOLDOWN_CYCLES + 2);

  states_t                 state;
  outerrors_t              err_r;
  biderrors_t              bid_err_r [NUMBIDDERS];
  logic [DATAWIDTH-1:0]    balance_r [NUMBIDDERS];
  logic [BIDAMTBITS-1:0]   last_bid  [NUMBIDDERS];
  logic [BIDAMTBITS-1:0]   bid_amt   [NUMBIDDERS];
  logic [NUMBIDDERS-1:0]   mask_r, ack_r, win_r, affordable;
  logic [DATAWIDTH-1:0]    timer_r, charge_r, key_r, round_cnt, max_bid_r;
  logic [CDW-1:0]          cd_cnt;
  logic                    round_over_r, round_end;
  logic [IDXW-1:0]         load_idx;

  logic [NUMBIDDERS*BIDAMTBITS-1:0] lb_flat;
  logic [BIDAMTBITS-1:0]            mf_max;
  logic                             mf_dup;
  logic [NUMBIDDERS-1:0]            mf_win;

`ifdef BIDS_RETRACT_EN
`else
  logic unused_retract;
  assign unused_retract = ^retract;
`endif

  for (genvar g = 0; g < NUMBIDDERS; g++) begin : g_lane
    assign bid_amt[g]                        = bidAmt[g*BIDAMTBITS +: BIDAMTBITS];
    assign lb_flat[g*BIDAMTBITS +: BIDAMTBITS] = last_bid[g];
    assign balance[g*DATAWIDTH +: DATAWIDTH]   = balance_r[g];
    assign bidErr[g*3 +: 3]                    = bid_err_r[g];
  end

  assign load_idx  = C_data[DATAWIDTH-1 -: IDXW];
  assign round_end = !C_start ||
                     (timer_r != '0 && (round_cnt + DATAWIDTH'(1)) == timer_r);

  // Sum is one bit wider than the balance so a large bid cannot wrap past it.
  always_comb begin
    affordable = '0;
    for (int i = 0; i < NUMBIDDERS; i++) begin
      affordable[i] = (SUMW'(bid_amt[i]) + SUMW'(charge_r)) <= SUMW'(balance_r[i]);
    end
  end

  bids_maxfind #(.N(NUMBIDDERS), .W(BIDAMTBITS)) u_maxfind (
    .vals       (lb_flat),
    .max_val    (mf_max),
    .dup        (mf_dup),
    .win_onehot (mf_win)
  );

  assign ack       = ack_r;
  assign win       = win_r;
  assign err       = err_r;
  assign roundOver = round_over_r;
  assign maxBid    = max_bid_r;
  assign ready     = (state == UNLOCKED) || (state == LOCKED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RESET;
      err_r        <= ERR_NONE;
      ack_r        <= '0;
      win_r        <= '0;
      round_over_r <= 1'b0;
      max_bid_r    <= '0;
      mask_r       <= '1;
      timer_r      <= '0;
      charge_r     <= '0;
      key_r        <= '0;
      round_cnt    <= '0;
      cd_cnt       <= '0;
      // NOTE: the per-bidder arrays are a handful of flops, not a RAM, and
      // reset must wipe any round in flight, so they are cleared here.
      for (int i = 0; i < NUMBIDDERS; i++) begin
        balance_r[i] <= '0;
        last_bid[i]  <= '0;
        bid_err_r[i] <= BID_OK;
      end
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples
      // pre-edge values; later assignments below override these defaults.
      err_r        <= ERR_NONE;
      ack_r        <= '0;
      win_r        <= '0;
      round_over_r <= 1'b0;
      for (int i = 0; i < NUMBIDDERS; i++) begin
        bid_err_r[i] <= bid[i] ? ROUNDINACTIVE : BID_OK;
      end

      case (state)
        RESET: state <= UNLOCKED;

        UNLOCKED: begin
          if (C_start) err_r <= CSTARTWHENUNLOCKED;
          case (C_op)
            UNLOCK: err_r <= ALREADYUNLOCKED;
            LOCK: begin
              key_r <= C_data;
              state <= LOCKED;
            end
            LOADBAL: begin
              if (int'(load_idx) >= NUMBIDDERS) err_r <= INVALID_OP;
              else balance_r[load_idx] <= DATAWIDTH'(C_data[BIDAMTBITS-1:0]);
            end
            SETMASK:      mask_r   <= C_data[NUMBIDDERS-1:0];
            SETTIMER:     timer_r  <= C_data;
            SETBIDCHARGE: charge_r <= C_data;
            default: ;
          endcase
        end

        COOLDOWN: begin
          if (cd_cnt <= CDW'(1)) begin
            cd_cnt <= '0;
            state  <= LOCKED;
          end else begin
            cd_cnt <= cd_cnt - CDW'(1);
          end
        end

        LOCKED: begin
          if (C_start) begin
            state     <= ROUNDSTARTED;
            round_cnt <= '0;
            for (int i = 0; i < NUMBIDDERS; i++) last_bid[i] <= '0;
          end else begin
            case (C_op)
              NO_OP: ;
              UNLOCK: begin
                if (C_data == key_r) begin
                  state <= UNLOCKED;
                end else begin
                  err_r  <= BADKEY;
                  state  <= COOLDOWN;
                  cd_cnt <= CDW'(COOLDOWN_CYCLES);
                end
              end
              default: err_r <= INVALID_OP;
            endcase
          end
        end

        ROUNDSTARTED: begin
          round_cnt <= round_cnt + DATAWIDTH'(1);
          if (round_end) begin
            state <= ROUNDOVER;
          end else begin
            for (int i = 0; i < NUMBIDDERS; i++) begin
`ifdef BIDS_RETRACT_EN
              if (retract[i]) begin
                if (last_bid[i] != '0) begin
                  last_bid[i]  <= '0;
                  ack_r[i]     <= 1'b1;
                  bid_err_r[i] <= BID_OK;
                end else begin
                  bid_err_r[i] <= INVALIDREQUEST;
                end
              end else
`endif
              if (bid[i]) begin
                if (!mask_r[i]) begin
                  bid_err_r[i] <= INVALIDREQUEST;
                end else if (!affordable[i]) begin
                  bid_err_r[i] <= INSUFFICIENTFUNDS;
                end else begin
                  bid_err_r[i] <= BID_OK;
                  ack_r[i]     <= 1'b1;
                  balance_r[i] <= balance_r[i] - charge_r;
                  last_bid[i]  <= bid_amt[i];
                end
              end
            end
          end
        end

        ROUNDOVER: begin
          state        <= READYNEXT;
          round_over_r <= 1'b1;
          if (mf_dup) begin
            err_r     <= DUPLICATEBIDS;
            max_bid_r <= '0;
          end else if (mf_max == '0) begin
            max_bid_r <= '0;
          end else begin
            win_r     <= mf_win;
            max_bid_r <= DATAWIDTH'(mf_max);
            for (int i = 0; i < NUMBIDDERS; i++) begin
              if (mf_win[i]) balance_r[i] <= balance_r[i] - DATAWIDTH'(last_bid[i]);
            end
          end
        end

        READYNEXT: if (!C_start) state <= LOCKED;

        default: state <= RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_bids_auction_n.sv
// Directed self-checking bench for bids_auction_n (3 bidders, 32-bit data).
module tb_bids_auction_n;
  import bids22defs::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] C_data;
  logic [3:0]  C_op;
  logic        C_start;
  logic [2:0]  bid, retract, ack, win;
  logic [47:0] bidAmt;
  logic [8:0]  bidErr;
  logic [95:0] balance;
  logic        ready, roundOver;
  logic [2:0]  err;
  logic [31:0] maxBid;

  int n_checks = 0;
  int n_errors = 0;

  bids_auction_n #(.DATAWIDTH(32), .NUMBIDDERS(3), .COOLDOWN_CYCLES(7)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .C_data    (C_data),
    .C_op      (C_op),
    .C_start   (C_start),
    .bid       (bid),
    .bidAmt    (bidAmt),
    .retract   (retract),
    .ack       (ack),
    .bidErr    (bidErr),
    .balance   (balance),
    .win       (win),
    .ready     (ready),
    .err       (err),
    .roundOver (roundOver),
    .maxBid    (maxBid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] o, input logic [31:0] d);
    C_op   = o;
    C_data = d;
    tick();
    C_op   = NO_OP;
    C_data = '0;
  endtask

  task automatic load(input int idx, input int val);
    op(LOADBAL, (32'(idx) << 30) | 32'(val));
  endtask

  initial begin
    reset_n = 1'b0;
    C_data  = '0;
    C_op    = NO_OP;
    C_start = 1'b0;
    bid     = '0;
    retract = '0;
    bidAmt  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   ready,   0);
    check("rst_balance", balance, 0);
    check("rst_maxbid",  maxBid,  0);
    check("rst_err",     err,     0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("unlocked_ready", ready, 1);

    C_start = 1'b1;
    tick();
    C_start = 1'b0;
    check("cstart_unlocked", err, CSTARTWHENUNLOCKED);

    load(0, 45);
    check("load0", balance, {32'd0, 32'd0, 32'd45});
    load(1, 46);
    load(2, 47);
    check("load_all", balance, {32'd47, 32'd46, 32'd45});
    load(3, 99);
    check("load_bad_idx_err", err, INVALID_OP);
    check("load_bad_idx_bal", balance, {32'd47, 32'd46, 32'd45});
    op(UNLOCK, 0);
    check("already_unlocked", err, ALREADYUNLOCKED);
    op(SETBIDCHARGE, 1);
    check("setcharge_err", err, ERR_NONE);

    // Wrong-key cooldown: 7 cycles in COOLDOWN, ops ignored meanwhile.
    op(LOCK, 12);
    check("locked_ready", ready, 1);
    op(UNLOCK, 5);
    check("badkey_err", err, BADKEY);
    check("badkey_ready", ready, 0);
    C_op   = UNLOCK;
    C_data = 12;
    repeat (6) tick();
    check("cooldown_6_ready", ready, 0);
    check("cooldown_ignored", err, ERR_NONE);
    tick();
    check("cooldown_7_ready", ready, 1);
    C_op   = NO_OP;
    C_data = '0;
    op(SETMASK, 7);
    check("locked_invalid_op", err, INVALID_OP);
    op(UNLOCK, 12);
    check("unlock_good_err", err, ERR_NONE);
    op(SETMASK, 7);
    check("unlocked_setmask", err, ERR_NONE);

    // Basic round: bids 2/1/1, charge 1.
    op(LOCK, 12);
    C_start = 1'b1;
    tick();
    check("round_ready", ready, 0);
    bid    = 3'b111;
    bidAmt = {16'd1, 16'd1, 16'd2};
    tick();
    check("basic_ack", ack, 3'b111);
    check("basic_charge", balance, {32'd46, 32'd45, 32'd44});
    bid     = '0;
    C_start = 1'b0;
    tick();
    tick();
    check("basic_win", win, 3'b001);
    check("basic_maxbid", maxBid, 2);
    check("basic_roundover", roundOver, 1);
    check("basic_balance", balance, {32'd46, 32'd45, 32'd42});
    bid    = 3'b001;
    bidAmt = {16'd0, 16'd0, 16'd2};
    tick();
    check("inactive_biderr", bidErr[2:0], ROUNDINACTIVE);
    check("inactive_ack", ack, 0);
    check("next_ready", ready, 1);
    check("maxbid_held", maxBid, 2);
    bid = '0;

    // Tie at the maximum.
    C_start = 1'b1;
    tick();
    bid    = 3'b111;
    bidAmt = {16'd1, 16'd3, 16'd3};
    tick();
    check("tie_ack", ack, 3'b111);
    bid     = '0;
    C_start = 1'b0;
    tick();
    tick();
    check("tie_err", err, DUPLICATEBIDS);
    check("tie_win", win, 0);
    check("tie_maxbid", maxBid, 0);
    check("tie_balance", balance, {32'd45, 32'd44, 32'd41});
    tick();

    // Funds: balance[1] = 2, charge 1; bid 2 fails, bid 1 fits exactly.
    op(UNLOCK, 12);
    load(1, 2);
    op(LOCK, 12);
    C_start = 1'b1;
    tick();
    bid    = 3'b010;
    bidAmt = {16'd0, 16'd2, 16'd0};
    tick();
    check("funds_biderr", bidErr[5:3], INSUFFICIENTFUNDS);
    check("funds_ack", ack, 0);
    check("funds_bal", balance[63:32], 2);
    bidAmt = {16'd0, 16'd1, 16'd0};
    tick();
    check("funds_edge_ack", ack, 3'b010);
    check("funds_edge_bal", balance[63:32], 1);
    bid     = '0;
    C_start = 1'b0;
    tick();
    tick();
    check("funds_win", win, 3'b010);
    check("funds_maxbid", maxBid, 1);
    check("funds_win_bal", balance[63:32], 0);
    tick();

    // Mask 3'b101: bidder 1 is rejected; an empty round gives no winner.
    op(UNLOCK, 12);
    op(SETMASK, 5);
    op(LOCK, 12);
    C_start = 1'b1;
    tick();
    bid    = 3'b010;
    bidAmt = {16'd0, 16'd1, 16'd0};
    tick();
    check("mask_biderr", bidErr[5:3], INVALIDREQUEST);
    check("mask_ack", ack, 0);
    bid     = '0;
    C_start = 1'b0;
    tick();
    tick();
    check("empty_win", win, 0);
    check("empty_maxbid", maxBid, 0);
    check("empty_err", err, ERR_NONE);
    check("empty_roundover", roundOver, 1);
    tick();

    // Timer 4 with C_start held: round ends on the 4th round cycle.
    op(UNLOCK, 12);
    op(SETTIMER, 4);
    op(SETMASK, 7);
    op(LOCK, 12);
    C_start = 1'b1;
    tick();
    bid    = 3'b001;
    bidAmt = {16'd0, 16'd0, 16'd3};
    tick();
    check("timer_r1_ack", ack, 3'b001);
    bid = '0;
    tick();
    tick();
    bid    = 3'b100;
    bidAmt = {16'd5, 16'd0, 16'd0};
    tick();
    check("timer_end_biderr", bidErr[8:6], ROUNDINACTIVE);
    check("timer_end_ack", ack, 0);
    check("timer_r4_roundover", roundOver, 0);
    bid = '0;
    tick();
    check("timer_r5_roundover", roundOver, 1);
    check("timer_win", win, 3'b001);
    check("timer_maxbid", maxBid, 3);
    check("timer_balance", balance[31:0], 37);
    tick();
    tick();
    check("readynext_hold", ready, 0);
    C_start = 1'b0;
    tick();
    check("readynext_release", ready, 1);

    // Retract: removes bidder 0 from contention only when the feature is built in.
    op(UNLOCK, 12);
    op(SETTIMER, 0);
    op(LOCK, 12);
    C_start = 1'b1;
    tick();
    bid    = 3'b101;
    bidAmt = {16'd2, 16'd0, 16'd3};
    tick();
    check("retract_bid_ack", ack, 3'b101);
    bid     = '0;
    retract = 3'b001;
    tick();
`ifdef BIDS_RETRACT_EN
    check("retract_ack", ack, 3'b001);
`else
    check("retract_ignored", ack, 0);
`endif
    retract = '0;
    C_start = 1'b0;
    tick();
    tick();
`ifdef BIDS_RETRACT_EN
    check("retract_win", win, 3'b100);
    check("retract_maxbid", maxBid, 2);
    check("retract_balance", balance, {32'd42, 32'd0, 32'd36});
`else
    check("noretract_win", win, 3'b001);
    check("noretract_maxbid", maxBid, 3);
    check("noretract_balance", balance, {32'd44, 32'd0, 32'd33});
`endif
    tick();

    // Asynchronous reset in the middle of a round.
    C_start = 1'b1;
    tick();
    bid    = 3'b001;
    bidAmt = {16'd0, 16'd0, 16'd1};
    tick();
    check("pre_reset_ack", ack, 3'b001);
    bid = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_ack", ack, 0);
    check("midreset_balance", balance, 0);
    check("midreset_ready", ready, 0);
    check("midreset_maxbid", maxBid, 0);
    check("midreset_win", win, 0);
    @(negedge clk);
    reset_n = 1'b1;
    C_start = 1'b0;
    tick();
    check("post_reset_ready", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
